// File: rtl/serial_adder.sv
// Multi-cycle add/subtract unit: ripples CHUNK bits per clock through a registered
// carry and publishes sum/carry/overflow with a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("serial_adder: WIDTH must be >= 1 and divisible by CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cy_q, cy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   off;
    logic [CHUNK-1:0]   a_slc;
    logic [CHUNK-1:0]   b_slc;
    logic [CHUNK:0]     slice;
    logic               msb_cin;
    logic               last;

    // One CHUNK-bit ripple slice; b_q already holds the effective (possibly inverted) B.
    always_comb begin
        off     = IDX_W'(cnt_q) * IDX_W'(CHUNK);
        a_slc   = a_q[off +: CHUNK];
        b_slc   = b_q[off +: CHUNK];
        slice   = {1'b0, a_slc} + {1'b0, b_slc} + (CHUNK+1)'(cy_q);
        msb_cin = slice[CHUNK-1] ^ a_slc[CHUNK-1] ^ b_slc[CHUNK-1];
        last    = (cnt_q == CNT_W'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    cy_d    = sub | c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[off +: CHUNK] = slice[CHUNK-1:0];
                cy_d  = slice[CHUNK];
                cnt_d = cnt_q + CNT_W'(1);
                // Final chunk: publish on the same edge the last slice lands.
                if (last) begin
                    state_d = DONE;
                    sum_d   = acc_d;
                    carry_d = slice[CHUNK];
                    ovf_d   = msb_cin ^ slice[CHUNK];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 16/4 directed and handshake cases plus an
// exhaustive 4-bit sweep over CHUNK = 1, 2, 4.
module tb_serial_adder;

    localparam int unsigned W = 16;
    localparam int unsigned C = 4;
    localparam int unsigned N = W / C;

    typedef struct packed {
        logic [31:0] acc;
        logic        v;
        logic        c;
        logic [15:0] s;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, c_in, sub;
    logic [W-1:0]  a, b;
    logic          busy, done, carry, ovf;
    logic [W-1:0]  sum;

    logic          sw_start, sw_cin, sw_sub;
    logic [3:0]    sw_a, sw_b;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [31:0]   cyc = '0;
    exp_t          q16[$];
    exp_t          e16;
    bit            chk_stable = 1'b0;
    logic [W-1:0]  last_sum = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    serial_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: full-width sum, signed overflow from operand/result signs.
    function automatic logic [17:0] model(input int unsigned w, input logic [15:0] x,
                                          input logic [15:0] y, input logic ci, input logic sb);
        logic [31:0] mask, be, full, s;
        logic        c, v;
        mask = (32'd1 << w) - 32'd1;
        be   = (sb ? ~{16'h0, y} : {16'h0, y}) & mask;
        full = {16'h0, x} + be + {31'h0, (sb ? 1'b1 : ci)};
        s    = full & mask;
        c    = full[w];
        v    = (x[w-1] == be[w-1]) && (s[w-1] != x[w-1]);
        return {v, c, s[15:0]};
    endfunction

    function automatic exp_t mk_exp(input int unsigned w, input logic [15:0] x, input logic [15:0] y,
                                    input logic ci, input logic sb, input logic [31:0] acc);
        logic [17:0] m;
        exp_t        e;
        m     = model(w, x, y, ci, sb);
        e.s   = m[15:0];
        e.c   = m[16];
        e.v   = m[17];
        e.acc = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (q16.size() == 0) begin
                check("m16_spurious_done", 32'd1, 32'd0);
            end else begin
                e16 = q16.pop_front();
                check("m16_sum",     32'(sum),   32'(e16.s));
                check("m16_carry",   32'(carry), 32'(e16.c));
                check("m16_ovf",     32'(ovf),   32'(e16.v));
                check("m16_latency", cyc - e16.acc, 32'(N));
            end
            last_sum = sum;
        end else if (chk_stable) begin
            check("m16_hold", 32'(sum), 32'(last_sum));
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int unsigned SC = 1 << g;
        localparam int unsigned SN = 4 / SC;
        logic       s_busy, s_done, s_c, s_v;
        logic [3:0] s_sum;
        exp_t       q[$];
        exp_t       e;

        serial_adder #(.WIDTH(4), .CHUNK(SC)) u_dut (
            .clk(clk), .rst(rst), .start(sw_start), .a(sw_a), .b(sw_b), .c_in(sw_cin),
            .sub(sw_sub), .busy(s_busy), .done(s_done), .sum(s_sum), .carry(s_c),
            .overflow(s_v)
        );

        always @(negedge clk) begin
            if (s_done) begin
                if (q.size() == 0) begin
                    check("sw_spurious_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sw_sum",     32'(s_sum), 32'(e.s));
                    check("sw_carry",   32'(s_c),   32'(e.c));
                    check("sw_ovf",     32'(s_v),   32'(e.v));
                    check("sw_latency", cyc - e.acc, 32'(SN));
                end
            end
        end
    end

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tci, input logic tsb);
        @(negedge clk);
        a = ta; b = tb; c_in = tci; sub = tsb; start = 1'b1;
        q16.push_back(mk_exp(W, ta, tb, tci, tsb, cyc + 32'd1));
        @(negedge clk);
        start = 1'b0;
        repeat (N + 1) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        sw_start = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_sum",   32'(sum),   32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        rst = 1'b0;

        // First add with cycle-by-cycle busy/done observation.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        q16.push_back(mk_exp(W, 16'h00FF, 16'h0001, 1'b0, 1'b0, cyc + 32'd1));
        for (int i = 0; i < int'(N); i++) begin
            @(negedge clk);
            start = 1'b0;
            check("hs_busy_run", 32'(busy), 32'd1);
            check("hs_done_run", 32'(done), 32'd0);
        end
        @(negedge clk);
        check("hs_busy_done", 32'(busy), 32'd0);
        check("hs_done_done", 32'(done), 32'd1);
        check("hs_sum_0100",  32'(sum),  32'h0100);
        @(negedge clk);
        check("hs_done_pulse", 32'(done), 32'd0);

        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h1234, 16'h0000, 1'b1, 1'b0);
        op16(16'h0005, 16'h0007, 1'b0, 1'b1);
        op16(16'h8000, 16'h0001, 1'b1, 1'b1);

        // Reset on the second RUN edge aborts the operation silently.
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_done",  32'(done),  32'd0);
        check("abort_sum",   32'(sum),   32'd0);
        check("abort_carry", 32'(carry), 32'd0);
        check("abort_ovf",   32'(ovf),   32'd0);
        rst = 1'b0;
        last_sum = '0;
        repeat (N + 3) @(negedge clk);
        op16(16'hA5A5, 16'h5A5B, 1'b0, 1'b0);

        // Start held high, operands churn every cycle: one accept per N+2 cycles.
        @(negedge clk);
        a = 16'h0F0F; b = 16'h00F1; c_in = 1'b1; sub = 1'b0; start = 1'b1;
        chk_stable = 1'b1;
        for (int k = 0; k < 3 * int'(N + 2); k++) begin
            if (k % int'(N + 2) == 0)
                q16.push_back(mk_exp(W, a, b, c_in, sub, cyc + 32'd1));
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
            c_in = 1'($urandom); sub = 1'($urandom);
        end
        start = 1'b0;
        chk_stable = 1'b0;
        repeat (N + 2) @(negedge clk);

        // Exhaustive 4-bit sweep over all three chunk sizes in parallel.
        for (int x = 0; x < 1024; x++) begin
            @(negedge clk);
            sw_a = 4'(x); sw_b = 4'(x >> 4); sw_cin = 1'(x >> 8); sw_sub = 1'(x >> 9);
            sw_start = 1'b1;
            g_sw[0].q.push_back(mk_exp(4, {12'h0, sw_a}, {12'h0, sw_b}, sw_cin, sw_sub, cyc + 32'd1));
            g_sw[1].q.push_back(mk_exp(4, {12'h0, sw_a}, {12'h0, sw_b}, sw_cin, sw_sub, cyc + 32'd1));
            g_sw[2].q.push_back(mk_exp(4, {12'h0, sw_a}, {12'h0, sw_b}, sw_cin, sw_sub, cyc + 32'd1));
            @(negedge clk);
            sw_start = 1'b0;
            repeat (5) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("drain_q16", 32'(q16.size()),       32'd0);
        check("drain_sw0", 32'(g_sw[0].q.size()), 32'd0);
        check("drain_sw1", 32'(g_sw[1].q.size()), 32'd0);
        check("drain_sw2", 32'(g_sw[2].q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised, multi-cycle add/subtract unit. It processes two WIDTH-bit operands CHUNK bits per clock through a registered ripple slice, with a start/busy/done handshake. It is the sequential successor to the single-bit full-adder cell, and it serves datapaths that trade latency for area. Results are held stable on the outputs until the next operation completes.

## Interface
- WIDTH, 16: operand and result width in bits. Must be ≥ 1.
- CHUNK, 4: bits processed per cycle. WIDTH must be divisible by CHUNK; elaboration fails otherwise. N = WIDTH/CHUNK.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset: synchronous and active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepted start edge.
- b  input  WIDTH  operand B, captured on the accepted start edge.
- c_in  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0: sum = a + b + c_in; 1: sum = a + ~b + 1 (a − b). Captured with the operands.
- busy  output  1  high while chunks are being processed (RUN state).
- done  output  1  one-cycle pulse: result registers just updated.
- sum  output  WIDTH  result of the last completed operation.
- carry  output  1  carry-out of the MSB. For sub: 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b, c_in and sub; clears the chunk counter; moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each edge adds chunk i (bits i·CHUNK .. i·CHUNK+CHUNK−1) of A and the effective B with the running carry. Chunk 0's carry-in is c_in for add and 1 for sub.
  - The partial sum is written into an internal accumulator, separate from the sum output register.
  - After chunk N−1 the state moves to DONE.
- DONE:
  - On the DONE-entry edge, sum, carry and overflow are loaded from the accumulator.
  - done=1 for exactly this cycle. The next edge returns to IDLE unconditionally.
- start in RUN or DONE is ignored; it is not queued. Input changes after the accept edge have no effect on the result in flight.
- Effective B is ~b when sub=1, else b. Arithmetic is modulo 2^WIDTH; carry and overflow are computed from the final chunk only.
- sum, carry and overflow change only on DONE entry or on reset. They hold their previous values through IDLE and RUN.
- Reset, in any state, mid-operation included:
  - state = IDLE; busy = 0; done = 0; sum = 0; carry = 0; overflow = 0; accumulator and counter cleared.
  - An aborted operation never asserts done.
  - rst dominates start on the same edge.

## Timing
- Start is accepted at edge E0. busy is high from after E0 through after E(N−1), i.e. N cycles.
- The state moves to DONE at edge EN. done is high, with results valid, between EN and EN+1.
- Latency from accepted start to done is N cycles.
- Minimum start-to-start spacing is N+2 cycles: IDLE must be re-entered at E(N+1) before the next start is sampled there.
- CHUNK=WIDTH gives N=1: busy for one cycle, done at E1.
- CHUNK=1 gives a fully bit-serial adder, N=WIDTH.
- Critical path is one CHUNK-bit ripple plus the carry register.

## Test plan
- Test plan defaults: WIDTH=16, CHUNK=4 (N=4) unless a scenario says otherwise.
- Add: a=0x00FF, b=0x0001, c_in=0, start at E0 -> busy high for 4 cycles; done at E4 only; sum=0x0100, carry=0, overflow=0.
- Wrap and overflow:
  - 0xFFFF + 0x0001 -> sum=0x0000, carry=1, overflow=0.
  - 0x7FFF + 0x0001 -> sum=0x8000, carry=0, overflow=1.
  - 0x1234 + 0x0000 with c_in=1 -> sum=0x1235.
- Subtract:
  - sub=1, 0x0005 − 0x0007 -> sum=0xFFFE, carry=0, overflow=0.
  - sub=1, 0x8000 − 0x0001 -> sum=0x7FFF, carry=1, overflow=1.
- Handshake:
  - start held high continuously, with a and b changed during RUN -> a single done per N+2 cycles.
  - Each result matches the operands captured at its accept edge.
  - sum stays stable between done pulses.
- Reset mid-operation: rst=1 on the second RUN edge -> next cycle busy=0, done=0, sum=0, carry=0, overflow=0; no done follows. A new start after rst=0 completes normally.
- Parameter sweep: WIDTH=4 with CHUNK=1, 2 and 4, all 2^10 combinations of a, b, c_in and sub -> results match a reference model; done latency is exactly 4, 2 and 1 cycles respectively.
